// File: rtl/mem_lsu_pkg.sv
// Shared widths, opcode/funct3 constants and the alignment rule for the
// memory stage.
package mem_lsu_pkg;

  localparam int RegBus     = 64;
  localparam int RegAddrBus = 5;
  localparam int CSRAddrBus = 12;

  localparam logic [6:0] Opcode_Load  = 7'b0000011;
  localparam logic [6:0] Opcode_Store = 7'b0100011;

  localparam logic [2:0] funct3_B  = 3'b000;
  localparam logic [2:0] funct3_H  = 3'b001;
  localparam logic [2:0] funct3_W  = 3'b010;
  localparam logic [2:0] funct3_D  = 3'b011;
  localparam logic [2:0] funct3_BU = 3'b100;
  localparam logic [2:0] funct3_HU = 3'b101;
  localparam logic [2:0] funct3_WU = 3'b110;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo[1:0];
      2'b11:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational load lane extraction/extension and store mask/data lane
// placement for a 64-bit data memory word.
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [RegBus-1:0] rdata_i,
  input  logic [RegBus-1:0] sdata_i,
  output logic [RegBus-1:0] load_data_o,
  output logic [7:0]        wmask_o,
  output logic [RegBus-1:0] wdata_o
);

  logic [RegBus-1:0] byte_sh, half_sh, word_sh;
  logic [7:0]        lb;
  logic [15:0]       lh;
  logic [31:0]       lw;

  always_comb begin
    byte_sh = rdata_i >> {addr_lo_i, 3'b000};
    half_sh = rdata_i >> {addr_lo_i[2:1], 4'b0000};
    word_sh = rdata_i >> {addr_lo_i[2], 5'b00000};
    lb = byte_sh[7:0];
    lh = half_sh[15:0];
    lw = word_sh[31:0];
    case (funct3_i)
      funct3_B:  load_data_o = {{56{lb[7]}}, lb};
      funct3_H:  load_data_o = {{48{lh[15]}}, lh};
      funct3_W:  load_data_o = {{32{lw[31]}}, lw};
      funct3_BU: load_data_o = {56'd0, lb};
      funct3_HU: load_data_o = {48'd0, lh};
      funct3_WU: load_data_o = {32'd0, lw};
      default:   load_data_o = rdata_i;
    endcase
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        wmask_o = 8'h01 << addr_lo_i;
        wdata_o = {56'd0, sdata_i[7:0]} << {addr_lo_i, 3'b000};
      end
      2'b01: begin
        wmask_o = 8'h03 << addr_lo_i;
        wdata_o = {48'd0, sdata_i[15:0]} << {addr_lo_i, 3'b000};
      end
      2'b10: begin
        wmask_o = 8'h0F << addr_lo_i;
        wdata_o = {32'd0, sdata_i[31:0]} << {addr_lo_i, 3'b000};
      end
      default: begin
        wmask_o = 8'hFF;
        wdata_o = sdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory stage: passes non-memory results through in one cycle and runs a
// request/ack handshake for aligned loads and stores, stalling upstream.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic [DATA_W-1:0]     store_data_i,
  input  logic [RegAddrBus-1:0] rd_addr_i,
  input  logic                  wreg_i,
  input  logic [CSRAddrBus-1:0] csr_waddr_i,
  input  logic                  csr_wreg_i,
  input  logic [DATA_W-1:0]     csr_wdata_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_W-1:0]     dmem_addr_o,
  output logic [7:0]            dmem_wmask_o,
  output logic [DATA_W-1:0]     dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_W-1:0]     dmem_rdata_i,
  output logic                  wb_valid_o,
  output logic                  wb_wreg_o,
  output logic [RegAddrBus-1:0] wb_rd_addr_o,
  output logic [DATA_W-1:0]     wb_wdata_o,
  output logic                  wb_csr_wreg_o,
  output logic [CSRAddrBus-1:0] wb_csr_waddr_o,
  output logic [DATA_W-1:0]     wb_csr_wdata_o,
  output logic [DATA_W-1:0]     mem_back_wdata_o,
  output logic [RegAddrBus-1:0] mem_back_rd_addr_o,
  output logic                  mem_back_wreg_o,
  output logic                  mem_back_csr_wreg_o,
  output logic [CSRAddrBus-1:0] mem_back_csr_waddr_o,
  output logic [DATA_W-1:0]     mem_back_csr_wdata_o,
  output logic                  misalign_o
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t                  state_q;
  logic                    req_q, we_q, is_load_q, wreg_q, csr_wreg_q;
  logic [2:0]              f3_q;
  logic [RegBus-1:0]       addr_q, sdata_q, csr_wdata_q;
  logic [RegAddrBus-1:0]   rd_q;
  logic [CSRAddrBus-1:0]   csr_waddr_q;

  logic                    wb_valid_q, wb_wreg_q, wb_csr_wreg_q, misalign_q;
  logic [RegAddrBus-1:0]   wb_rd_q;
  logic [RegBus-1:0]       wb_wdata_q, wb_csr_wdata_q;
  logic [CSRAddrBus-1:0]   wb_csr_waddr_q;

  logic                    is_load, is_store, is_mem, mis;
  logic [RegBus-1:0]       load_data, st_wdata;
  logic [7:0]              st_wmask;

  assign is_load  = (opcode_i == Opcode_Load);
  assign is_store = (opcode_i == Opcode_Store);
  assign is_mem   = is_load | is_store;
  assign mis      = is_mem & misaligned(funct3_i, ex_wdata_i[2:0]);

  // Driven from captured fields so addr/mask/data stay stable across the wait.
  mem_align u_align (
    .funct3_i    (f3_q),
    .addr_lo_i   (addr_q[2:0]),
    .rdata_i     (dmem_rdata_i),
    .sdata_i     (sdata_q),
    .load_data_o (load_data),
    .wmask_o     (st_wmask),
    .wdata_o     (st_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      is_load_q      <= 1'b0;
      wreg_q         <= 1'b0;
      csr_wreg_q     <= 1'b0;
      f3_q           <= '0;
      addr_q         <= '0;
      sdata_q        <= '0;
      csr_wdata_q    <= '0;
      rd_q           <= '0;
      csr_waddr_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_wreg_q      <= 1'b0;
      wb_csr_wreg_q  <= 1'b0;
      misalign_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_wdata_q     <= '0;
      wb_csr_wdata_q <= '0;
      wb_csr_waddr_q <= '0;
    end else begin
      wb_valid_q    <= 1'b0;
      wb_wreg_q     <= 1'b0;
      wb_csr_wreg_q <= 1'b0;
      misalign_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            if (is_mem && !mis) begin
              state_q     <= S_REQ;
              req_q       <= 1'b1;
              we_q        <= is_store;
              is_load_q   <= is_load;
              f3_q        <= funct3_i;
              addr_q      <= ex_wdata_i;
              sdata_q     <= store_data_i;
              rd_q        <= rd_addr_i;
              wreg_q      <= wreg_i;
              csr_waddr_q <= csr_waddr_i;
              csr_wreg_q  <= csr_wreg_i;
              csr_wdata_q <= csr_wdata_i;
            end else begin
              wb_valid_q     <= 1'b1;
              wb_rd_q        <= rd_addr_i;
              wb_wdata_q     <= ex_wdata_i;
              wb_csr_waddr_q <= csr_waddr_i;
              wb_csr_wdata_q <= csr_wdata_i;
              if (mis) begin
                misalign_q <= 1'b1;
              end else begin
                wb_wreg_q     <= wreg_i;
                wb_csr_wreg_q <= csr_wreg_i;
              end
            end
          end
        end
        S_REQ: begin
          if (dmem_ack_i) begin
            state_q        <= S_IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            wb_valid_q     <= 1'b1;
            wb_rd_q        <= rd_q;
            wb_wdata_q     <= is_load_q ? load_data : addr_q;
            wb_wreg_q      <= is_load_q & wreg_q;
            wb_csr_wreg_q  <= csr_wreg_q;
            wb_csr_waddr_q <= csr_waddr_q;
            wb_csr_wdata_q <= csr_wdata_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall_o      = (state_q == S_REQ);
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
  assign dmem_wmask_o = we_q ? st_wmask : 8'h00;
  assign dmem_wdata_o = we_q ? st_wdata : '0;

  assign wb_valid_o     = wb_valid_q;
  assign wb_wreg_o      = wb_wreg_q;
  assign wb_rd_addr_o   = wb_rd_q;
  assign wb_wdata_o     = wb_wdata_q;
  assign wb_csr_wreg_o  = wb_csr_wreg_q;
  assign wb_csr_waddr_o = wb_csr_waddr_q;
  assign wb_csr_wdata_o = wb_csr_wdata_q;
  assign misalign_o     = misalign_q;

  assign mem_back_wdata_o     = wb_wdata_q;
  assign mem_back_rd_addr_o   = wb_rd_q;
  assign mem_back_wreg_o      = wb_wreg_q;
  assign mem_back_csr_wreg_o  = wb_csr_wreg_q;
  assign mem_back_csr_waddr_o = wb_csr_waddr_q;
  assign mem_back_csr_wdata_o = wb_csr_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, load/store handshakes,
// misalignment, reset mid-access and back-to-back issue.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [63:0] ex_wdata_i, store_data_i, csr_wdata_i, dmem_rdata_i;
  logic [4:0]  rd_addr_i;
  logic        wreg_i, csr_wreg_i, dmem_ack_i;
  logic [11:0] csr_waddr_i;

  logic        stall_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_wreg_o, wb_csr_wreg_o, misalign_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o, wb_wdata_o, wb_csr_wdata_o, mem_back_wdata_o, mem_back_csr_wdata_o;
  logic [7:0]  dmem_wmask_o;
  logic [4:0]  wb_rd_addr_o, mem_back_rd_addr_o;
  logic [11:0] wb_csr_waddr_o, mem_back_csr_waddr_o;
  logic        mem_back_wreg_o, mem_back_csr_wreg_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_lsu dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .ex_wdata_i(ex_wdata_i), .store_data_i(store_data_i), .rd_addr_i(rd_addr_i), .wreg_i(wreg_i),
    .csr_waddr_i(csr_waddr_i), .csr_wreg_i(csr_wreg_i), .csr_wdata_i(csr_wdata_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wmask_o(dmem_wmask_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_wreg_o(wb_wreg_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_wdata_o(wb_wdata_o), .wb_csr_wreg_o(wb_csr_wreg_o),
    .wb_csr_waddr_o(wb_csr_waddr_o), .wb_csr_wdata_o(wb_csr_wdata_o),
    .mem_back_wdata_o(mem_back_wdata_o), .mem_back_rd_addr_o(mem_back_rd_addr_o),
    .mem_back_wreg_o(mem_back_wreg_o), .mem_back_csr_wreg_o(mem_back_csr_wreg_o),
    .mem_back_csr_waddr_o(mem_back_csr_waddr_o), .mem_back_csr_wdata_o(mem_back_csr_wdata_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sd, input logic [4:0] rd, input logic wr);
    in_valid_i   = 1'b1;
    opcode_i     = opc;
    funct3_i     = f3;
    ex_wdata_i   = a;
    store_data_i = sd;
    rd_addr_i    = rd;
    wreg_i       = wr;
  endtask

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; opcode_i = '0; funct3_i = '0; ex_wdata_i = '0;
    store_data_i = '0; rd_addr_i = '0; wreg_i = 1'b0; csr_waddr_i = '0; csr_wreg_i = 1'b0;
    csr_wdata_i = '0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_req", 64'(dmem_req_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_misalign", 64'(misalign_o), 64'd0);
    chk("rst_wdata", wb_wdata_o, 64'd0);

    // ADDI with a CSR side write
    issue(7'b0010011, 3'b000, 64'h5, 64'h0, 5'd3, 1'b1);
    csr_wreg_i = 1'b1; csr_waddr_i = 12'h300; csr_wdata_i = 64'h1234;
    tick();
    in_valid_i = 1'b0; csr_wreg_i = 1'b0;
    chk("addi_valid", 64'(wb_valid_o), 64'd1);
    chk("addi_wreg", 64'(wb_wreg_o), 64'd1);
    chk("addi_rd", 64'(wb_rd_addr_o), 64'd3);
    chk("addi_wdata", wb_wdata_o, 64'h5);
    chk("addi_stall", 64'(stall_o), 64'd0);
    chk("addi_csr_wreg", 64'(wb_csr_wreg_o), 64'd1);
    chk("addi_csr_addr", 64'(wb_csr_waddr_o), 64'h300);
    tick();
    chk("idle_valid", 64'(wb_valid_o), 64'd0);
    chk("idle_csr_wreg", 64'(wb_csr_wreg_o), 64'd0);
    chk("idle_hold_wdata", wb_wdata_o, 64'h5);

    // LB 0x1003, ack on the third request cycle
    issue(7'b0000011, 3'b000, 64'h1003, 64'h0, 5'd7, 1'b1);
    tick();
    in_valid_i = 1'b0;
    chk("lb_req_c1", 64'(dmem_req_o), 64'd1);
    chk("lb_stall_c1", 64'(stall_o), 64'd1);
    chk("lb_we", 64'(dmem_we_o), 64'd0);
    chk("lb_addr", dmem_addr_o, 64'h1000);
    tick();
    chk("lb_req_c2", 64'(dmem_req_o), 64'd1);
    chk("lb_wbv_c2", 64'(wb_valid_o), 64'd0);
    tick();
    chk("lb_req_c3", 64'(dmem_req_o), 64'd1);
    chk("lb_addr_c3", dmem_addr_o, 64'h1000);
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'h0000_0000_8000_0000;
    tick();
    dmem_ack_i = 1'b0;
    chk("lb_wb_valid", 64'(wb_valid_o), 64'd1);
    chk("lb_wdata", wb_wdata_o, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_rd", 64'(wb_rd_addr_o), 64'd7);
    chk("lb_wreg", 64'(wb_wreg_o), 64'd1);
    chk("lb_req_after", 64'(dmem_req_o), 64'd0);
    chk("lb_stall_after", 64'(stall_o), 64'd0);

    // SH 0x2006
    issue(7'b0100011, 3'b001, 64'h2006, 64'hABCD, 5'd4, 1'b1);
    tick();
    in_valid_i = 1'b0;
    chk("sh_req", 64'(dmem_req_o), 64'd1);
    chk("sh_we", 64'(dmem_we_o), 64'd1);
    chk("sh_mask", 64'(dmem_wmask_o), 64'hC0);
    chk("sh_lane", 64'(dmem_wdata_o[63:48]), 64'hABCD);
    chk("sh_addr", dmem_addr_o, 64'h2000);
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    chk("sh_wb_valid", 64'(wb_valid_o), 64'd1);
    chk("sh_wb_wreg", 64'(wb_wreg_o), 64'd0);

    // LW 0x3002 misaligned
    issue(7'b0000011, 3'b010, 64'h3002, 64'h0, 5'd5, 1'b1);
    tick();
    in_valid_i = 1'b0;
    chk("lw_mis_req", 64'(dmem_req_o), 64'd0);
    chk("lw_mis_stall", 64'(stall_o), 64'd0);
    chk("lw_mis_flag", 64'(misalign_o), 64'd1);
    chk("lw_mis_valid", 64'(wb_valid_o), 64'd1);
    chk("lw_mis_wreg", 64'(wb_wreg_o), 64'd0);
    tick();
    chk("lw_mis_clear", 64'(misalign_o), 64'd0);

    // Stray ack while idle
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    chk("idle_ack_valid", 64'(wb_valid_o), 64'd0);
    chk("idle_ack_stall", 64'(stall_o), 64'd0);

    // Reset during REQ, then a late ack
    issue(7'b0000011, 3'b011, 64'h4000, 64'h0, 5'd6, 1'b1);
    tick();
    in_valid_i = 1'b0;
    chk("rreq_req", 64'(dmem_req_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rreq_req_after", 64'(dmem_req_o), 64'd0);
    chk("rreq_stall_after", 64'(stall_o), 64'd0);
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'hDEAD_BEEF_0000_0001;
    tick();
    dmem_ack_i = 1'b0;
    chk("rreq_late_ack", 64'(wb_valid_o), 64'd0);
    chk("rreq_late_req", 64'(dmem_req_o), 64'd0);

    // LD then ADD back-to-back
    issue(7'b0000011, 3'b011, 64'h5008, 64'h0, 5'd9, 1'b1);
    tick();
    in_valid_i = 1'b0;
    chk("ld_req", 64'(dmem_req_o), 64'd1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'h1122_3344_5566_7788;
    tick();
    dmem_ack_i = 1'b0;
    chk("ld_wdata", wb_wdata_o, 64'h1122_3344_5566_7788);
    chk("ld_back_wdata", mem_back_wdata_o, 64'h1122_3344_5566_7788);
    chk("ld_back_rd", 64'(mem_back_rd_addr_o), 64'd9);
    chk("ld_back_wreg", 64'(mem_back_wreg_o), 64'd1);
    chk("ld_stall", 64'(stall_o), 64'd0);
    issue(7'b0110011, 3'b000, 64'h77, 64'h0, 5'd10, 1'b1);
    tick();
    in_valid_i = 1'b0;
    chk("add_valid", 64'(wb_valid_o), 64'd1);
    chk("add_rd", 64'(wb_rd_addr_o), 64'd10);
    chk("add_wdata", wb_wdata_o, 64'h77);
    chk("add_req", 64'(dmem_req_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
